jtag_tap_responder: RTL and testbench

Synthesizable IEEE 1149.1 TAP responder, the target end of the simulation JTAG link. It oversamples the host-driven `jtag_TCK/TMS/TDI/TRSTn` wires on the system `clock` and runs the 16-state TAP controller. It implements IDCODE, BYPASS and a 32-bit user data register, and returns `jtag_TDO_data/jtag_TDO_driven` to the JTAG host model. It sits opposite the JTAG host in the debug path and replaces the external DTM in loopback tests.

---
 rtl/jtag_tap_pkg.sv | 61 ++++++
 rtl/jtag_tap_sync.sv | 48 ++++
 rtl/jtag_tap_responder.sv | 168 ++++++++++++++++
 tb/tb_jtag_tap_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP controller types, widths, opcodes and the 1149.1 state transition helper.
package jtag_tap_pkg;

   localparam int unsigned IR_WIDTH = 5;
   localparam int unsigned DR_WIDTH = 32;

   localparam logic [IR_WIDTH-1:0] IR_IDCODE  = 5'h01;
   localparam logic [IR_WIDTH-1:0] IR_USER    = 5'h10;
   localparam logic [IR_WIDTH-1:0] IR_BYPASS  = 5'h1F;
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 5'b00001;

   typedef enum logic [3:0] {
      TapEx2Dr = 4'h0,
      TapEx1Dr = 4'h1,
      TapShDr  = 4'h2,
      TapPauDr = 4'h3,
      TapSelIr = 4'h4,
      TapUpdDr = 4'h5,
      TapCapDr = 4'h6,
      TapSelDr = 4'h7,
      TapEx2Ir = 4'h8,
      TapEx1Ir = 4'h9,
      TapShIr  = 4'hA,
      TapPauIr = 4'hB,
      TapRti   = 4'hC,
      TapUpdIr = 4'hD,
      TapCapIr = 4'hE,
      TapTlr   = 4'hF
   } tap_state_e;

   typedef enum logic [1:0] {
      DrBypass,
      DrIdcode,
      DrUser
   } dr_sel_e;

   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      tap_state_e n;
      case (s)
         TapTlr:   n = tms ? TapTlr   : TapRti;
         TapRti:   n = tms ? TapSelDr : TapRti;
         TapSelDr: n = tms ? TapSelIr : TapCapDr;
         TapCapDr: n = tms ? TapEx1Dr : TapShDr;
         TapShDr:  n = tms ? TapEx1Dr : TapShDr;
         TapEx1Dr: n = tms ? TapUpdDr : TapPauDr;
         TapPauDr: n = tms ? TapEx2Dr : TapPauDr;
         TapEx2Dr: n = tms ? TapUpdDr : TapShDr;
         TapUpdDr: n = tms ? TapSelDr : TapRti;
         TapSelIr: n = tms ? TapTlr   : TapCapIr;
         TapCapIr: n = tms ? TapEx1Ir : TapShIr;
         TapShIr:  n = tms ? TapEx1Ir : TapShIr;
         TapEx1Ir: n = tms ? TapUpdIr : TapPauIr;
         TapPauIr: n = tms ? TapEx2Ir : TapPauIr;
         TapEx2Ir: n = tms ? TapUpdIr : TapShIr;
         TapUpdIr: n = tms ? TapSelDr : TapRti;
         default:  n = TapTlr;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jtag_tap_sync.sv
// Oversampling synchronizer for the host-driven JTAG pins, with TCK rise/fall strobes
// derived from the last synchronizer stage and one history flop.
module jtag_tap_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic tck,
   input  logic tms,
   input  logic tdi,
   input  logic trstn,
   output logic tms_sync,
   output logic tdi_sync,
   output logic trstn_sync,
   output logic tck_rise,
   output logic tck_fall
);

   logic [SYNC_STAGES-1:0] tck_q;
   logic [SYNC_STAGES-1:0] tms_q;
   logic [SYNC_STAGES-1:0] tdi_q;
   logic [SYNC_STAGES-1:0] trstn_q;
   logic                   tck_hist_q;

   // Idle pin levels on reset so no spurious edge or test reset is seen on release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tck_q      <= '0;
         tms_q      <= '1;
         tdi_q      <= '0;
         trstn_q    <= '1;
         tck_hist_q <= 1'b0;
      end else begin
         tck_q      <= {tck_q[SYNC_STAGES-2:0], tck};
         tms_q      <= {tms_q[SYNC_STAGES-2:0], tms};
         tdi_q      <= {tdi_q[SYNC_STAGES-2:0], tdi};
         trstn_q    <= {trstn_q[SYNC_STAGES-2:0], trstn};
         tck_hist_q <= tck_q[SYNC_STAGES-1];
      end
   end

   assign tms_sync   = tms_q[SYNC_STAGES-1];
   assign tdi_sync   = tdi_q[SYNC_STAGES-1];
   assign trstn_sync = trstn_q[SYNC_STAGES-1];
   assign tck_rise   = tck_q[SYNC_STAGES-1] & ~tck_hist_q;
   assign tck_fall   = ~tck_q[SYNC_STAGES-1] & tck_hist_q;

endmodule

// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP responder clocked by the system clock: IDCODE, BYPASS and an optional
// 32-bit user DR enabled by defining JTAG_TAP_USER_DR_EN.
module jtag_tap_responder
   import jtag_tap_pkg::*;
#(
   parameter logic [DR_WIDTH-1:0] IDCODE      = 32'h1000_0001,
   parameter int unsigned         SYNC_STAGES = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                jtag_TCK,
   input  logic                jtag_TMS,
   input  logic                jtag_TDI,
   input  logic                jtag_TRSTn,
   output logic                jtag_TDO_data,
   output logic                jtag_TDO_driven,
   input  logic [DR_WIDTH-1:0] user_capture,
   output logic [DR_WIDTH-1:0] user_data,
   output logic                user_update,
   output logic [3:0]          tap_state
);

   tap_state_e          state_q, state_d;
   logic [IR_WIDTH-1:0] ir_q, ir_sr_q;
   logic [DR_WIDTH-1:0] dr_sr_q;
   logic                bypass_q;
   logic                tdo_q, driven_q, tdo_d;
   dr_sel_e             dr_sel;
   logic                tms_s, tdi_s, trstn_s, tck_rise, tck_fall;

   jtag_tap_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clock     (clock),
      .reset     (reset),
      .tck       (jtag_TCK),
      .tms       (jtag_TMS),
      .tdi       (jtag_TDI),
      .trstn     (jtag_TRSTn),
      .tms_sync  (tms_s),
      .tdi_sync  (tdi_s),
      .trstn_sync(trstn_s),
      .tck_rise  (tck_rise),
      .tck_fall  (tck_fall)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= TapTlr;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!trstn_s) begin
         state_d = TapTlr;
      end else if (tck_rise) begin
         state_d = tap_next(state_q, tms_s);
      end
   end

   always_comb begin
      case (ir_q)
         IR_IDCODE: dr_sel = DrIdcode;
`ifdef JTAG_TAP_USER_DR_EN
         IR_USER:   dr_sel = DrUser;
`else
         IR_USER:   dr_sel = DrBypass;
`endif
         IR_BYPASS: dr_sel = DrBypass;
         default:   dr_sel = DrBypass;
      endcase
   end

   always_comb begin
      tdo_d = dr_sr_q[0];
      if (state_q == TapShIr) begin
         tdo_d = ir_sr_q[0];
      end else if (dr_sel == DrBypass) begin
         tdo_d = bypass_q;
      end
   end

   // Test reset wins over any TCK edge seen in the same clock.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ir_q     <= IR_IDCODE;
         ir_sr_q  <= '0;
         dr_sr_q  <= '0;
         bypass_q <= 1'b0;
         tdo_q    <= 1'b0;
         driven_q <= 1'b0;
      end else if (!trstn_s) begin
         ir_q     <= IR_IDCODE;
         ir_sr_q  <= '0;
         dr_sr_q  <= '0;
         bypass_q <= 1'b0;
         tdo_q    <= 1'b0;
         driven_q <= 1'b0;
      end else begin
         if (tck_rise) begin
            case (state_q)
               TapCapIr: ir_sr_q <= IR_CAPTURE;
               TapShIr:  ir_sr_q <= {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
               TapCapDr: begin
                  case (dr_sel)
                     DrIdcode: dr_sr_q <= IDCODE;
`ifdef JTAG_TAP_USER_DR_EN
                     DrUser:   dr_sr_q <= user_capture;
`endif
                     default:  bypass_q <= 1'b0;
                  endcase
               end
               TapShDr: begin
                  if (dr_sel == DrBypass) begin
                     bypass_q <= tdi_s;
                  end else begin
                     dr_sr_q <= {tdi_s, dr_sr_q[DR_WIDTH-1:1]};
                  end
               end
               default: ;
            endcase
            if (state_d == TapTlr) begin
               ir_q <= IR_IDCODE;
            end else if (state_d == TapUpdIr) begin
               ir_q <= ir_sr_q;
            end
         end
         if (tck_fall) begin
            tdo_q    <= tdo_d;
            driven_q <= (state_q == TapShDr) || (state_q == TapShIr);
         end
      end
   end

`ifdef JTAG_TAP_USER_DR_EN
   logic [DR_WIDTH-1:0] user_data_q;
   logic                user_update_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         user_data_q   <= '0;
         user_update_q <= 1'b0;
      end else begin
         user_update_q <= 1'b0;
         if (tck_rise && trstn_s && state_d == TapUpdDr && dr_sel == DrUser) begin
            user_data_q   <= dr_sr_q;
            user_update_q <= 1'b1;
         end
      end
   end

   assign user_data   = user_data_q;
   assign user_update = user_update_q;
`else
   logic unused_user_capture;
   assign unused_user_capture = ^user_capture;
   assign user_data           = '0;
   assign user_update         = 1'b0;
`endif

   assign jtag_TDO_data   = tdo_q;
   assign jtag_TDO_driven = driven_q;
   assign tap_state       = state_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Bench for jtag_tap_responder: scripted and random TAP traffic drives a reference model that
// queues expected state/TDO/update values; independent monitors pop and compare them.
`timescale 1ns/1ps
module tb_jtag_tap_responder;

   localparam logic [31:0] IDC  = 32'h1000_0001;
   localparam int          SYNC = 2;
`ifdef JTAG_TAP_USER_DR_EN
   localparam bit USER_EN = 1'b1;
`else
   localparam bit USER_EN = 1'b0;
`endif
   localparam logic [3:0] S_TLR   = 4'hF;
   localparam logic [3:0] S_CAPDR = 4'h6;
   localparam logic [3:0] S_SHDR  = 4'h2;
   localparam logic [3:0] S_UPDDR = 4'h5;
   localparam logic [3:0] S_CAPIR = 4'hE;
   localparam logic [3:0] S_SHIR  = 4'hA;
   localparam logic [3:0] S_UPDIR = 4'hD;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        jtag_TCK = 1'b0;
   logic        jtag_TMS = 1'b1;
   logic        jtag_TDI = 1'b0;
   logic        jtag_TRSTn = 1'b1;
   logic        jtag_TDO_data, jtag_TDO_driven, user_update;
   logic [31:0] user_capture = 32'h0;
   logic [31:0] user_data;
   logic [3:0]  tap_state;

   int n_checks = 0;
   int n_pass   = 0;
   bit armed    = 1'b0;
   bit upd_prev = 1'b0;

   // Reference model: standard 1149.1 transition table indexed by state code.
   logic [3:0]  nxt0 [16];
   logic [3:0]  nxt1 [16];
   logic [3:0]  m_state;
   logic [4:0]  m_ir, m_irsr;
   logic [31:0] m_dr;

   logic [3:0]  exp_state [$];
   logic [1:0]  exp_out [$];
   logic [31:0] exp_upd [$];

   jtag_tap_responder #(
      .IDCODE     (IDC),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .jtag_TCK       (jtag_TCK),
      .jtag_TMS       (jtag_TMS),
      .jtag_TDI       (jtag_TDI),
      .jtag_TRSTn     (jtag_TRSTn),
      .jtag_TDO_data  (jtag_TDO_data),
      .jtag_TDO_driven(jtag_TDO_driven),
      .user_capture   (user_capture),
      .user_data      (user_data),
      .user_update    (user_update),
      .tap_state      (tap_state)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
   endtask

   function automatic int dr_len(input logic [4:0] ir);
      if (ir == 5'h01) return 32;
      if (USER_EN && ir == 5'h10) return 32;
      return 1;
   endfunction

   task automatic model_reset();
      m_state = S_TLR;
      m_ir    = 5'h01;
      m_irsr  = 5'h00;
      m_dr    = 32'h0;
   endtask

   task automatic model_rise(input bit tms, input bit tdi);
      int         len;
      logic [3:0] nxt;
      len = dr_len(m_ir);
      nxt = tms ? nxt1[m_state] : nxt0[m_state];
      if (m_state == S_CAPIR) m_irsr = 5'b00001;
      if (m_state == S_SHIR) m_irsr = (m_irsr >> 1) | (5'(tdi) << 4);
      if (m_state == S_CAPDR) begin
         if (m_ir == 5'h01) m_dr = IDC;
         else if (len == 32) m_dr = user_capture;
         else m_dr = 32'h0;
      end
      if (m_state == S_SHDR) begin
         m_dr = (m_dr >> 1) | (32'(tdi) << (len - 1));
         if (len == 1) m_dr = m_dr & 32'h1;
      end
      if (nxt == S_TLR) m_ir = 5'h01;
      if (nxt == S_UPDIR) m_ir = m_irsr;
      if (nxt == S_UPDDR && USER_EN && m_ir == 5'h10) exp_upd.push_back(m_dr);
      m_state = nxt;
      exp_state.push_back(nxt);
   endtask

   task automatic model_fall();
      logic drv;
      drv = (m_state == S_SHDR) || (m_state == S_SHIR);
      exp_out.push_back({drv, (m_state == S_SHIR) ? m_irsr[0] : m_dr[0]});
   endtask

   task automatic tck(input bit tms, input bit tdi);
      jtag_TMS = tms;
      jtag_TDI = tdi;
      repeat (3) @(negedge clock);
      model_rise(tms, tdi);
      jtag_TCK = 1'b1;
      repeat (6) @(negedge clock);
      model_fall();
      jtag_TCK = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   // Both scans start and end in Run-Test/Idle.
   task automatic shift_ir(input logic [4:0] v);
      tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
      for (int i = 0; i < 5; i++) tck(i == 4, v[i]);
      tck(1, 0); tck(0, 0);
   endtask

   task automatic shift_dr(input logic [31:0] v, input int n);
      tck(1, 0); tck(0, 0); tck(0, 0);
      for (int i = 0; i < n; i++) tck(i == n - 1, v[i]);
      tck(1, 0); tck(0, 0);
   endtask

   always @(posedge jtag_TCK) begin
      if (armed) begin
         repeat (SYNC + 2) @(posedge clock);
         @(negedge clock);
         if (exp_state.size() == 0) begin
            n_checks++;
            $display("FAIL tap_state: got %h with no expectation queued", tap_state);
         end else begin
            check("tap_state", 32'(tap_state), 32'(exp_state.pop_front()));
         end
      end
   end

   always @(negedge jtag_TCK) begin
      logic [1:0] e;
      if (armed) begin
         repeat (SYNC + 2) @(posedge clock);
         @(negedge clock);
         if (exp_out.size() == 0) begin
            n_checks++;
            $display("FAIL tdo: got driven=%b with no expectation queued", jtag_TDO_driven);
         end else begin
            e = exp_out.pop_front();
            check("tdo_driven", 32'(jtag_TDO_driven), 32'(e[1]));
            if (e[1]) check("tdo_data", 32'(jtag_TDO_data), 32'(e[0]));
         end
      end
   end

   always @(negedge clock) begin
      if (user_update) begin
         check("user_update_width", 32'(upd_prev), 32'h0);
         if (exp_upd.size() == 0) begin
            n_checks++;
            $display("FAIL user_update: got a pulse, required none");
         end else begin
            check("user_data", user_data, exp_upd.pop_front());
         end
      end
      upd_prev = user_update;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: got no finish, required one within 3ms");
      $fatal(1);
   end

   initial begin
      nxt0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
               4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
      nxt1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
               4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
      model_reset();
      repeat (5) @(negedge clock);
      check("reset_tap_state", 32'(tap_state), 32'hF);
      check("reset_tdo_data", 32'(jtag_TDO_data), 32'h0);
      check("reset_tdo_driven", 32'(jtag_TDO_driven), 32'h0);
      check("reset_user_data", user_data, 32'h0);
      check("reset_user_update", 32'(user_update), 32'h0);
      reset = 1'b1;
      repeat (4) @(negedge clock);
      armed = 1'b1;

      tck(0, 0);
      shift_dr($urandom, 32);                       // IDCODE after reset
      shift_ir(5'h1F);
      shift_dr(32'h0000_000D, 5);                   // BYPASS: TDI 1,0,1,1,...
      shift_ir(5'h00);                              // captured 00001 out, IR becomes 0
      shift_dr($urandom, 3);

      user_capture = 32'h1234_5678;
      shift_ir(5'h10);
      shift_dr(32'hDEAD_BEEF, 32);
      repeat (4) @(negedge clock);
      check("user_data_after_upd", user_data, USER_EN ? 32'hDEAD_BEEF : 32'h0);
      user_capture = $urandom;
      shift_dr($urandom, 32);

      // Test reset in the middle of a DR shift.
      shift_ir(5'h1F);
      tck(1, 0); tck(0, 0); tck(0, 0);
      for (int i = 0; i < 3; i++) tck(0, 1'($urandom));
      repeat (3) @(negedge clock);
      jtag_TRSTn = 1'b0;
      repeat (6) @(negedge clock);
      check("trst_tap_state", 32'(tap_state), 32'hF);
      check("trst_tdo_driven", 32'(jtag_TDO_driven), 32'h0);
      model_reset();
      jtag_TRSTn = 1'b1;
      repeat (4) @(negedge clock);
      tck(0, 0);
      shift_dr($urandom, 32);                       // IR must be back to IDCODE

      // Five TMS=1 rises from Shift-IR.
      shift_ir(5'h1F);
      tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
      tck(0, 1); tck(0, 0);
      for (int i = 0; i < 5; i++) tck(1, 0);
      repeat (2) @(negedge clock);
      check("tms_reset_tap_state", 32'(tap_state), 32'hF);
      check("tms_reset_tdo_driven", 32'(jtag_TDO_driven), 32'h0);
      tck(0, 0);
      shift_dr($urandom, 32);

      // Random walk through the whole state graph.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) user_capture = $urandom;
         tck(1'($urandom), 1'($urandom));
      end

      // System reset mid-transaction.
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_mid_tap_state", 32'(tap_state), 32'hF);
      check("rst_mid_user_data", user_data, 32'h0);
      model_reset();
      reset = 1'b1;
      repeat (4) @(negedge clock);
      tck(0, 0);
      shift_dr($urandom, 32);

      repeat (10) @(negedge clock);
      check("state_queue_drained", 32'(exp_state.size()), 32'h0);
      check("tdo_queue_drained", 32'(exp_out.size()), 32'h0);
      check("upd_queue_drained", 32'(exp_upd.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
